// File: rtl/alu_exec_stage.sv
// Execute/writeback stage for the 16-bit ALU. It holds the register file and
// PSW, latches one instruction per cycle and forwards the in-flight result.
module alu_exec_stage #(
  parameter int NREG = 8,
  parameter int DW   = 16,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_func,
  input  logic [AW-1:0] in_src,
  input  logic [AW-1:0] in_dst,
  input  logic [DW-1:0] in_imm,
  input  logic          in_imm_sel,
  input  logic          in_wr,
  input  logic          in_flag,
  input  logic          hold,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_func,
  output logic          cin,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_c,
  input  logic          alu_z,
  input  logic          alu_v,
  input  logic          alu_s,
  output logic [3:0]    psw,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          div_err,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  // Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
  // in_ready is low exactly while hold is high.

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [3:0]    psw_q, psw_d;
  logic          e_valid_q, e_valid_d;
  logic [3:0]    e_func_q, e_func_d;
  logic [AW-1:0] e_dst_q, e_dst_d;
  logic          e_wr_q, e_wr_d;
  logic          e_flag_q, e_flag_d;
  logic [DW-1:0] op_a_q, op_a_d;
  logic [DW-1:0] op_b_q, op_b_d;
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          div_err_q, div_err_d;

  logic div0;
  logic commit;
  logic commit_now;
  logic fwd_src_hit;
  logic fwd_dst_hit;

  assign div0       = (e_func_q == 4'b1000) && (op_a_q == '0);
  assign commit     = e_valid_q && !hold;
  assign commit_now = commit && !div0;
  // A divide-by-zero never forwards, so its dependents read the unchanged file.
  assign fwd_src_hit = commit_now && e_wr_q && (e_dst_q == in_src);
  assign fwd_dst_hit = commit_now && e_wr_q && (e_dst_q == in_dst);

  always_comb begin
    regs_d     = regs_q;
    psw_d      = psw_q;
    e_valid_d  = e_valid_q;
    e_func_d   = e_func_q;
    e_dst_d    = e_dst_q;
    e_wr_d     = e_wr_q;
    e_flag_d   = e_flag_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    div_err_d  = div_err_q;

    if (commit) begin
      if (div0) begin
        div_err_d = 1'b1;
      end else begin
        if (e_wr_q) begin
          regs_d[e_dst_q] = alu_out;
          wb_valid_d      = 1'b1;
          wb_addr_d       = e_dst_q;
          wb_data_d       = alu_out;
        end
        if (e_flag_q) begin
          psw_d = {alu_c, alu_z, alu_v, alu_s};
        end
      end
    end

    if (!hold) begin
      e_valid_d = in_valid;
      if (in_valid) begin
        e_func_d = in_func;
        e_dst_d  = in_dst;
        e_wr_d   = in_wr;
        e_flag_d = in_flag;
        op_a_d   = in_imm_sel ? in_imm : (fwd_src_hit ? alu_out : regs_q[in_src]);
        op_b_d   = fwd_dst_hit ? alu_out : regs_q[in_dst];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      psw_q      <= '0;
      e_valid_q  <= 1'b0;
      e_func_q   <= '0;
      e_dst_q    <= '0;
      e_wr_q     <= 1'b0;
      e_flag_q   <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      div_err_q  <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      psw_q      <= psw_d;
      e_valid_q  <= e_valid_d;
      e_func_q   <= e_func_d;
      e_dst_q    <= e_dst_d;
      e_wr_q     <= e_wr_d;
      e_flag_q   <= e_flag_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      div_err_q  <= div_err_d;
    end
  end

  assign in_ready = !hold;
  assign alu_a    = op_a_q;
  assign alu_b    = op_b_q;
  assign alu_func = e_func_q;
  assign cin      = psw_q[3];
  assign psw      = psw_q;
  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign div_err  = div_err_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a behavioural ALU and a writeback
// scoreboard keyed on {wb_addr, wb_data}.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_func;
  logic [2:0]  in_src, in_dst;
  logic [15:0] in_imm;
  logic        in_imm_sel, in_wr, in_flag, hold;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_func;
  logic        cin, alu_c, alu_z, alu_v, alu_s;
  logic [3:0]  psw;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        div_err;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_wb = -10;
  int prev_wb = -20;
  logic [18:0] exp_q[$];

  alu_exec_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_src(in_src), .in_dst(in_dst), .in_imm(in_imm),
    .in_imm_sel(in_imm_sel), .in_wr(in_wr), .in_flag(in_flag), .hold(hold),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .cin(cin),
    .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z), .alu_v(alu_v), .alu_s(alu_s),
    .psw(psw), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .div_err(div_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: ADD uses carry-in, OR, DIV as alu_b / alu_a.
  logic [16:0] sum17;
  always_comb begin
    sum17   = 17'd0;
    alu_out = 16'd0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_func)
      4'b0000: begin
        sum17   = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, cin};
        alu_out = sum17[15:0];
        alu_c   = sum17[16];
        alu_v   = (alu_a[15] == alu_b[15]) && (sum17[15] != alu_a[15]);
      end
      4'b0011: alu_out = alu_a | alu_b;
      4'b1000: alu_out = (alu_a != 16'd0) ? alu_b / alu_a : 16'd0;
      default: alu_out = 16'd0;
    endcase
    alu_z = (alu_out == 16'd0);
    alu_s = alu_out[15];
  end

  task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every writeback pulse must match the oldest expected commit.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (wb_valid === 1'b1) begin
        prev_wb = last_wb;
        last_wb = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL wb_unexpected observed=%h expected=none", {wb_addr, wb_data});
        end else begin
          check("wb", {wb_addr, wb_data}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [3:0] f, input logic [2:0] s, input logic [2:0] d,
                       input logic [15:0] imm, input logic sel, input logic wr,
                       input logic fl);
    @(negedge clk);
    in_valid = 1'b1; in_func = f; in_src = s; in_dst = d;
    in_imm = imm; in_imm_sel = sel; in_wr = wr; in_flag = fl;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [15:0] v);
    dbg_addr = a;
    #1;
    check(tag, {3'd0, dbg_data}, {3'd0, v});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_func = '0; in_src = '0; in_dst = '0;
    in_imm = '0; in_imm_sel = 1'b0; in_wr = 1'b0; in_flag = 1'b0;
    hold = 1'b0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) check_reg("reset_reg", 3'(i), 16'h0000);
    check("reset_psw", {15'd0, psw}, 19'd0);
    check("reset_div_err", {18'd0, div_err}, 19'd0);
    check("reset_in_ready", {18'd0, in_ready}, 19'd1);
    check("reset_wb_valid", {18'd0, wb_valid}, 19'd0);

    // ADD R1 = imm 5 + R1, flags updated
    issue(4'b0000, 3'd0, 3'd1, 16'h0005, 1'b1, 1'b1, 1'b1);
    exp_q.push_back({3'd1, 16'h0005});
    idle(3);
    check_reg("add_r1", 3'd1, 16'h0005);
    check("add_psw", {15'd0, psw}, 19'd0);

    // Back-to-back dependent pair through forwarding
    issue(4'b0000, 3'd0, 3'd1, 16'h0003, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({3'd1, 16'h0008});
    issue(4'b0000, 3'd1, 3'd2, 16'h0000, 1'b0, 1'b1, 1'b0);
    exp_q.push_back({3'd2, 16'h0008});
    idle(3);
    check_reg("fwd_r1", 3'd1, 16'h0008);
    check_reg("fwd_r2", 3'd2, 16'h0008);
    check("wb_consecutive", 19'(last_wb - prev_wb), 19'd1);

    // Carry chain: OR then ADD setting C, then ADD consuming cin
    issue(4'b0011, 3'd0, 3'd3, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({3'd3, 16'hFFFF});
    issue(4'b0000, 3'd0, 3'd3, 16'h0001, 1'b1, 1'b1, 1'b1);
    exp_q.push_back({3'd3, 16'h0000});
    issue(4'b0000, 3'd0, 3'd4, 16'h0000, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({3'd4, 16'h0001});
    idle(3);
    check_reg("carry_r3", 3'd3, 16'h0000);
    check_reg("carry_r4", 3'd4, 16'h0001);
    check("carry_psw", {15'd0, psw}, 19'b1100);

    // Divide by zero, then a dependent that must not see a forwarded value
    issue(4'b1000, 3'd0, 3'd1, 16'h0000, 1'b1, 1'b1, 1'b1);
    issue(4'b0000, 3'd1, 3'd2, 16'h0000, 1'b0, 1'b1, 1'b0);
    exp_q.push_back({3'd2, 16'h0011});
    issue(4'b0000, 3'd0, 3'd6, 16'h0002, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({3'd6, 16'h0003});
    idle(3);
    check_reg("div0_r1", 3'd1, 16'h0008);
    check_reg("div0_dep_r2", 3'd2, 16'h0011);
    check_reg("div0_r6", 3'd6, 16'h0003);
    check("div0_psw", {15'd0, psw}, 19'b1100);
    check("div_err_sticky", {18'd0, div_err}, 19'd1);

    // Clear C, then hold ADD R5 += 7 in E for three cycles
    issue(4'b0000, 3'd0, 3'd7, 16'h0000, 1'b1, 1'b1, 1'b1);
    exp_q.push_back({3'd7, 16'h0001});
    issue(4'b0000, 3'd0, 3'd5, 16'h0007, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({3'd5, 16'h0007});
    @(negedge clk);
    in_valid = 1'b0; hold = 1'b1; dbg_addr = 3'd5;
    #1;
    check("hold_in_ready", {18'd0, in_ready}, 19'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("hold_no_wb", {18'd0, wb_valid}, 19'd0);
      check_reg("hold_r5", 3'd5, 16'h0000);
    end
    hold = 1'b0;
    @(negedge clk);
    #1;
    check("release_wb", {18'd0, wb_valid}, 19'd1);
    check_reg("release_r5", 3'd5, 16'h0007);
    check_reg("hold_r7", 3'd7, 16'h0001);
    check("hold_psw", {15'd0, psw}, 19'd0);
    check("div_err_still", {18'd0, div_err}, 19'd1);

    // Async reset in the middle of a hold discards the held instruction
    issue(4'b0000, 3'd0, 3'd5, 16'h0007, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; hold = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reg("rst_r5", 3'd5, 16'h0000);
    check("rst_psw", {15'd0, psw}, 19'd0);
    check("rst_div_err", {18'd0, div_err}, 19'd0);
    check("rst_alu_a", {3'd0, alu_a}, 19'd0);
    check("rst_in_ready_hold", {18'd0, in_ready}, 19'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    hold = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("post_rst_no_wb", {18'd0, wb_valid}, 19'd0);
    end
    check_reg("post_rst_r5", 3'd5, 16'h0000);
    check("scoreboard_empty", 19'(exp_q.size()), 19'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
